prog_sequencer: RTL



---
 rtl/prog_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: PC generation, runtime-writable branch LUT, req/done
// handshake and a saturating count of RUN cycles.
module prog_sequencer #(
  parameter int D        = 12,
  parameter int LW       = 3,
  parameter int END_ADDR = 128,
  parameter int CW       = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req_i,
  input  logic          stall_i,
  input  logic [2:0]    branch_i,
  input  logic          cnd_i,
  input  logic [LW-1:0] lut_idx_i,
  input  logic [D-1:0]  rel_off_i,
  input  logic          lut_we_i,
  input  logic [LW-1:0] lut_waddr_i,
  input  logic [D-1:0]  lut_wdata_i,
  output logic [D-1:0]  prog_ctr_o,
  output logic          fetch_valid_o,
  output logic          running_o,
  output logic          done_o,
  output logic [CW-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [D-1:0]  EndPc  = D'(END_ADDR);
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  lut_q [2**LW];
  logic [D-1:0]  next_pc;
  logic          lut_wr;

  // Branch target selection; the LUT read is combinational so a branch
  // resolves in the same cycle its index is presented.
  always_comb begin
    next_pc = pc_q + D'(1);
    unique case (branch_i)
      3'b001:  next_pc = lut_q[lut_idx_i];
      3'b010:  if (cnd_i) next_pc = lut_q[lut_idx_i];
      3'b011:  if (cnd_i) next_pc = pc_q + rel_off_i;
      default: next_pc = pc_q + D'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    lut_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        lut_wr = lut_we_i;
        if (req_i) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CW'(1);
        // Stall outranks every branch mode, halt included.
        if (!stall_i) begin
          if (branch_i == 3'b100) begin
            state_d = DONE;
          end else begin
            pc_d = next_pc;
            if (next_pc == EndPc) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2**LW; i++) lut_q[i] <= '0;
    end else if (lut_wr) begin
      lut_q[lut_waddr_i] <= lut_wdata_i;
    end
  end

  assign prog_ctr_o    = pc_q;
  assign running_o     = (state_q == RUN);
  assign fetch_valid_o = (state_q == RUN) && !stall_i;
  assign done_o        = (state_q == DONE);
  assign cycle_cnt_o   = cnt_q;

endmodule
